uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: pops bytes from the transmit FIFO's read side and shifts each out as one frame: start bit, 8 data bits LSB first, odd parity, stop bit. Each bit is held for a fixed number of bit-clock cycles. It sits in the bit-clock domain opposite the receive path, and its frame format matches what the receiver samples.

## Interface
- CLKS_PER_BIT, 8, bit-clock cycles each serial bit is held; legal range 2..255.
- tx_sclk_i  input  1  bit clock; all state updates on its rising edge.
- tx_srst_i  input  1  reset, synchronous, active-high.
- rdata_i  input  8  FIFO read data; first-word-fall-through, valid whenever rempty_i is low.
- rempty_i  input  1  FIFO empty flag.
- rinc_o  output  1  FIFO pop strobe; one cycle per byte.
- tx_data_o  output  1  serial line; idles high.
- tx_busy_o  output  1  high from the cycle after the pop through the last stop-bit cycle.

## Operation
- State machine is one-hot with five states.
  - IDLE -> START when rempty_i=0; otherwise stays in IDLE.
  - START -> DATA.
  - DATA -> PARITY after bit 7.
  - PARITY -> STOP.
  - STOP -> IDLE.
- rinc_o = IDLE & ~rempty_i & ~tx_srst_i. It is combinational and asserts for exactly one cycle per frame.
- In the pop cycle, rdata_i is loaded into an 8-bit shift register, and parity = ~^rdata_i (odd parity) is latched.
- Bit counter (3 bits): indexes data bits 0..7. It increments at the end of each DATA bit and clears in IDLE.
- Cycle counter (width $clog2(CLKS_PER_BIT)):
  - Clears on entry to every serial state.
  - Increments each cycle within that state.
  - The bit ends when it equals CLKS_PER_BIT-1.
- tx_data_o is registered:
  - 0 in START.
  - shreg[0] in DATA; the register shifts right at each bit end.
  - Latched parity in PARITY.
  - 1 in STOP and IDLE.
- rdata_i is ignored outside the pop cycle. Changes to rempty_i mid-frame have no effect.
- Reset values: state=IDLE, tx_data_o=1, tx_busy_o=0, rinc_o=0, counters=0, shift register=0.
- Reset mid-frame: the frame is abandoned. tx_data_o=1 on the next edge. The popped byte is lost and not re-fetched.
- Reset asserted together with a pop condition: rinc_o stays 0 and nothing is popped.

## Timing
- Pop at cycle N. Start bit drives the line during cycles N+1 .. N+CLKS_PER_BIT.
- Data bit k occupies cycles N+1+(k+1)*CLKS_PER_BIT onward, for CLKS_PER_BIT cycles.
- Frame length on the line is 11*CLKS_PER_BIT cycles, or 10*CLKS_PER_BIT without parity.
- After STOP there is exactly one mandatory IDLE cycle. The next pop can occur in that cycle.
- Back-to-back frame period is therefore 11*CLKS_PER_BIT+1 cycles.
- tx_busy_o is registered and rises together with the start bit at N+1. It falls in the IDLE cycle.

## Configuration
- UART_TX_PARITY_EN
  - Defined: PARITY state is present and the frame carries odd parity.
  - Undefined: the PARITY state, parity register, and logic are removed, and DATA -> STOP directly. The frame is 10 bits.
- The same macro gates parity checking on the receive side, so both ends stay matched.

## Structure
- Shared package uart_pkg holds:
  - State index constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - DATA_BITS=8.
  - Default CLKS_PER_BIT.
  - Frame-length constants, used by both TX and RX.
- Sub-module uart_bit_timer: a CLKS_PER_BIT cycle counter with clear input and bit_end output. It is reusable by the receiver's sampler.

## Test plan
- Reset with FIFO non-empty:
  - During reset: rinc_o=0, tx_data_o=1.
  - First pop occurs on the first cycle after reset deasserts.
- Single byte 0xA5, CLKS_PER_BIT=8:
  - Line sequence: 0, 1,0,1,0,0,1,0,1, parity 1, 1, each bit 8 cycles.
  - rinc_o asserts once.
  - tx_busy_o is high for 88 cycles.
- Byte 0x01: parity bit = 0.
- Byte 0xFF: parity bit = 1.
- Byte 0x00: parity bit = 1.
- Two queued bytes 0x3C, 0xC3:
  - Second rinc_o fires exactly 89 cycles after the first.
  - The line stays high for exactly 1 cycle between frames.
- Reset asserted in data bit 4 of a frame:
  - Line goes high next cycle; state returns to IDLE.
  - With FIFO empty, no further output and rinc_o stays 0.
- Build without UART_TX_PARITY_EN, byte 0x81:
  - Frame is 80 cycles: stop bit follows bit 7 directly, with no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//
// Contents:
//   - State index constants for the one-hot serial state machine.
//   - One-hot state encoding (state_t).
//   - Data width, default bit period and frame-length constants.
//   - odd_parity(): parity bit that makes the total count of ones odd.
//
// Configuration macro: UART_TX_PARITY_EN
//   Defined   : PARITY state exists and frames carry an odd parity bit (11 bits).
//   Undefined : PARITY state is removed and frames are 10 bits.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Bit positions of each state inside the one-hot state vector.
    localparam int ST_IDLE    = 0;
    localparam int ST_START   = 1;
    localparam int ST_DATA    = 2;
    localparam int ST_PARITY  = 3;
    localparam int ST_STOP    = 4;
    localparam int NUM_STATES = 5;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 8;

    // Frame lengths in serial bits: start + data + optional parity + stop.
    localparam int FRAME_BITS_PARITY    = 1 + DATA_BITS + 1 + 1;
    localparam int FRAME_BITS_NO_PARITY = 1 + DATA_BITS + 1;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

    typedef enum logic [NUM_STATES-1:0] {
        S_IDLE   = NUM_STATES'(1 << ST_IDLE),
        S_START  = NUM_STATES'(1 << ST_START),
        S_DATA   = NUM_STATES'(1 << ST_DATA),
`ifdef UART_TX_PARITY_EN
        S_PARITY = NUM_STATES'(1 << ST_PARITY),
`endif
        S_STOP   = NUM_STATES'(1 << ST_STOP)
    } state_t;

    // Odd parity: the returned bit plus the data always holds an odd number of ones.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts cycles of one serial bit period. The count restarts from zero after
// every bit end, so a new bit period begins on the cycle after bit_end without
// any help from the caller. Holding clr high parks the count at zero.
//
// Parameters:
//   CLKS_PER_BIT  cycles per serial bit (2..255)
//
// Ports:
//   clk      in   clock, all updates on rising edge
//   rst      in   synchronous active-high reset
//   clr      in   hold the counter at zero
//   bit_end  out  high on the last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. Pops one byte at a time from a first-word-fall-
// through FIFO and shifts it out as: start bit (0), 8 data bits LSB first,
// optional odd parity bit, stop bit (1). Each bit is held CLKS_PER_BIT cycles.
// After the stop bit the machine spends exactly one cycle in IDLE, where the
// next byte may already be popped.
//
// Configuration macro: UART_TX_PARITY_EN
//   Defined   : odd parity bit sent between bit 7 and the stop bit.
//   Undefined : no parity state or register; bit 7 is followed by the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  bit-clock cycles per serial bit (2..255)
//
// Ports:
//   tx_sclk_i  in   bit clock
//   tx_srst_i  in   synchronous active-high reset
//   rdata_i    in   [7:0] FIFO read data (valid while rempty_i is low)
//   rempty_i   in   FIFO empty flag
//   rinc_o     out  FIFO pop strobe, one cycle per frame (combinational)
//   tx_data_o  out  serial line, idles high (registered)
//   tx_busy_o  out  high from start bit through last stop-bit cycle (registered)
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 tx_sclk_i,
    input  logic                 tx_srst_i,
    input  logic [DATA_BITS-1:0] rdata_i,
    input  logic                 rempty_i,
    output logic                 rinc_o,
    output logic                 tx_data_o,
    output logic                 tx_busy_o
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS);

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 bit_end;
    logic                 last_data_bit;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    // Reset is folded in so a pop can never coincide with a reset edge.
    assign rinc_o = (state == S_IDLE) & ~rempty_i & ~tx_srst_i;

    assign last_data_bit = (bit_cnt == BIT_CNT_W'(DATA_BITS - 1));

    // The timer is parked at zero in IDLE, so the start bit gets a full period
    // counted from the cycle after the pop.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (tx_sclk_i),
        .rst     (tx_srst_i),
        .clr     (state == S_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge tx_sclk_i) begin
        if (tx_srst_i) begin
            state     <= S_IDLE;
            tx_data_o <= 1'b1;
            tx_busy_o <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    tx_data_o <= 1'b1;
                    tx_busy_o <= 1'b0;
                    bit_cnt   <= '0;
                    if (rinc_o) begin
                        shreg     <= rdata_i;
`ifdef UART_TX_PARITY_EN
                        parity    <= odd_parity(rdata_i);
`endif
                        state     <= S_START;
                        tx_data_o <= 1'b0;
                        tx_busy_o <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        state     <= S_DATA;
                        tx_data_o <= shreg[0];
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (last_data_bit) begin
`ifdef UART_TX_PARITY_EN
                            state     <= S_PARITY;
                            tx_data_o <= parity;
`else
                            state     <= S_STOP;
                            tx_data_o <= 1'b1;
`endif
                        end else begin
                            // Next bit is the one about to land in shreg[0].
                            tx_data_o <= shreg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state     <= S_STOP;
                        tx_data_o <= 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        state     <= S_IDLE;
                        tx_data_o <= 1'b1;
                        tx_busy_o <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    tx_data_o <= 1'b1;
                    tx_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed testbench for uart_tx with CLKS_PER_BIT = 8. Follows the build's
// UART_TX_PARITY_EN setting to choose 11- or 10-bit frames.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int C = 8;
`ifdef UART_TX_PARITY_EN
    localparam int  FRAME = 11;
    localparam bit  PAR   = 1'b1;
`else
    localparam int  FRAME = 10;
    localparam bit  PAR   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc;
    logic       tx_data;
    logic       tx_busy;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int t0;

    uart_tx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .tx_sclk_i (clk),
        .tx_srst_i (rst),
        .rdata_i   (rdata),
        .rempty_i  (rempty),
        .rinc_o    (rinc),
        .tx_data_o (tx_data),
        .tx_busy_o (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called 2 time units into cycle N+1 (first start-bit cycle). Walks the whole
    // frame cycle by cycle, then checks the single IDLE cycle that follows.
    task automatic check_frame(input logic [7:0] d, input logic par, input string tag);
        for (int i = 0; i < FRAME * C; i++) begin
            int   b;
            logic e;
            b = i / C;
            if (b == 0)                 e = 1'b0;
            else if (b <= 8)            e = d[b-1];
            else if (PAR && b == 9)     e = par;
            else                        e = 1'b1;
            chk(tx_data, e,    $sformatf("%s_line_bit%0d", tag, b));
            chk(tx_busy, 1'b1, $sformatf("%s_busy_bit%0d", tag, b));
            chk(rinc,    1'b0, $sformatf("%s_nopop_bit%0d", tag, b));
            @(posedge clk); #2;
        end
        chk(tx_data, 1'b1, {tag, "_idle_line"});
        chk(tx_busy, 1'b0, {tag, "_idle_busy"});
    endtask

    // Called 2 time units into an IDLE cycle: offers one byte, expects the pop
    // in this very cycle, then empties the FIFO and scrambles rdata.
    task automatic send(input logic [7:0] d, input logic par, input string tag);
        rdata  = d;
        rempty = 1'b0;
        #1;
        chk(rinc, 1'b1, {tag, "_pop"});
        @(posedge clk); #1;
        rempty = 1'b1;
        rdata  = ~d;
        #1;
        check_frame(d, par, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a byte waiting in the FIFO.
        rst    = 1'b1;
        rempty = 1'b0;
        rdata  = 8'hA5;
        repeat (3) begin
            @(posedge clk); #2;
            chk(rinc,    1'b0, "rst_rinc");
            chk(tx_data, 1'b1, "rst_line");
            chk(tx_busy, 1'b0, "rst_busy");
        end
        rst = 1'b0;

        // First cycle out of reset pops 0xA5 (odd parity bit 1).
        send(8'hA5, 1'b1, "a5");

        send(8'h01, 1'b0, "x01");
        send(8'hFF, 1'b1, "xff");

        // Two queued bytes: FIFO stays non-empty across the first frame.
        rdata  = 8'h3C;
        rempty = 1'b0;
        #1;
        chk(rinc, 1'b1, "q0_pop");
        t0 = cyc;
        @(posedge clk); #1;
        rdata = 8'hC3;
        #1;
        check_frame(8'h3C, 1'b1, "q0");
        #1;
        chk(rinc, 1'b1, "q1_pop");
        chk(cyc - t0, FRAME * C + 1, "q_pop_spacing");
        @(posedge clk); #1;
        rempty = 1'b1;
        #1;
        check_frame(8'hC3, 1'b1, "q1");

        // Reset during data bit 4 of 0x0F (bit 4 is a 0 on the line).
        rdata  = 8'h0F;
        rempty = 1'b0;
        #1;
        chk(rinc, 1'b1, "r_pop");
        @(posedge clk); #1;
        rempty = 1'b1;
        #1;
        repeat (5 * C + 2) @(posedge clk);
        #2;
        chk(tx_data, 1'b0, "r_mid_bit4");
        chk(tx_busy, 1'b1, "r_mid_busy");
        rst = 1'b1;
        #1;
        chk(rinc, 1'b0, "r_assert_rinc");
        @(posedge clk); #2;
        chk(tx_data, 1'b1, "r_after_line");
        chk(tx_busy, 1'b0, "r_after_busy");
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #2;
            chk(tx_data, 1'b1, "r_quiet_line");
            chk(rinc,    1'b0, "r_quiet_rinc");
            chk(tx_busy, 1'b0, "r_quiet_busy");
        end

        // Back in IDLE: a new byte is popped immediately.
        send(8'h00, 1'b1, "x00");
        send(8'h81, 1'b1, "x81");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
